// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the request/response channels of both requesters together with the
// ALU operand/result bus that the arbiter drives.
//   slave  modport : used by alu_arbiter (receives requests, drives responses
//                    and the ALU inputs, samples alu_out)
//   master modport : used by the environment (requesters plus the ALU itself)
// Parameters: WIDTH (operand/result width), OP_WIDTH (op-code width).
interface alu_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
);
    logic                req0_valid;
    logic                req0_ready;
    logic [WIDTH-1:0]    req0_in_a;
    logic [WIDTH-1:0]    req0_in_b;
    logic [OP_WIDTH-1:0] req0_op_code;
    logic                req1_valid;
    logic                req1_ready;
    logic [WIDTH-1:0]    req1_in_a;
    logic [WIDTH-1:0]    req1_in_b;
    logic [OP_WIDTH-1:0] req1_op_code;
    logic                rsp0_valid;
    logic                rsp0_ready;
    logic                rsp1_valid;
    logic                rsp1_ready;
    logic [WIDTH-1:0]    rsp_out;
    logic [WIDTH-1:0]    alu_in_a;
    logic [WIDTH-1:0]    alu_in_b;
    logic [OP_WIDTH-1:0] alu_op_code;
    logic [WIDTH-1:0]    alu_out;

    modport slave (
        input  req0_valid, req0_in_a, req0_in_b, req0_op_code,
        input  req1_valid, req1_in_a, req1_in_b, req1_op_code,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out,
        output alu_in_a, alu_in_b, alu_op_code
    );

    modport master (
        output req0_valid, req0_in_a, req0_in_b, req0_op_code,
        output req1_valid, req1_in_a, req1_in_b, req1_op_code,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_out,
        input  alu_in_a, alu_in_b, alu_op_code
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between port 0 (integer pipeline) and port 1
// (auxiliary sequencer). The granted port's operands drive the ALU; on the
// request handshake alu_out is captured into a single result register that is
// returned to the owning port and held until that port accepts it.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (discards any pending result)
//   bus     : alu_arbiter_if.slave - request/response channels and ALU bus
// Configuration macro:
//   ALU_ARB_RR_EN : defined -> round-robin tie break; undefined -> port 0
//                   always wins ties (fixed priority).
module alu_arbiter #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_r;
    logic             owner_r;
    logic             prio_r;
    logic [WIDTH-1:0] result_r;

    logic grant0_s;
    logic grant1_s;
    logic owner_ready_s;
    logic can_accept_s;
    logic drain_s;
    logic hs0_s;
    logic hs1_s;

    // Ready of the port currently owning the result register.
    always_comb begin
        owner_ready_s = 1'b0;
        if (owner_r) begin
            owner_ready_s = bus.rsp1_ready;
        end else begin
            owner_ready_s = bus.rsp0_ready;
        end
    end

    // Register is free, or is being drained this cycle; nothing is accepted
    // while reset is asserted.
    assign drain_s      = (state_r == ST_FULL) & owner_ready_s;
    assign can_accept_s = reset_n & ((state_r == ST_EMPTY) | owner_ready_s);

    // Grant among valid requests; prio_r decides a tie. Grant is independent
    // of can_accept so the ALU inputs follow a blocked requester.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case ({bus.req1_valid, bus.req0_valid})
            2'b01:   grant0_s = 1'b1;
            2'b10:   grant1_s = 1'b1;
            2'b11: begin
                if (prio_r) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
        if (!reset_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            grant0_s = grant0_s;
            grant1_s = grant1_s;
        end
    end

    assign bus.req0_ready = grant0_s & can_accept_s;
    assign bus.req1_ready = grant1_s & can_accept_s;
    assign hs0_s = bus.req0_valid & bus.req0_ready;
    assign hs1_s = bus.req1_valid & bus.req1_ready;

    // ALU operand mux: granted port, or all-zero when nothing is granted.
    always_comb begin
        bus.alu_in_a    = {WIDTH{1'b0}};
        bus.alu_in_b    = {WIDTH{1'b0}};
        bus.alu_op_code = {OP_WIDTH{1'b0}};
        case ({grant1_s, grant0_s})
            2'b01: begin
                bus.alu_in_a    = bus.req0_in_a;
                bus.alu_in_b    = bus.req0_in_b;
                bus.alu_op_code = bus.req0_op_code;
            end
            2'b10: begin
                bus.alu_in_a    = bus.req1_in_a;
                bus.alu_in_b    = bus.req1_in_b;
                bus.alu_op_code = bus.req1_op_code;
            end
            default: begin
                bus.alu_in_a    = {WIDTH{1'b0}};
                bus.alu_in_b    = {WIDTH{1'b0}};
                bus.alu_op_code = {OP_WIDTH{1'b0}};
            end
        endcase
    end

    // Result register, owner, state and tie-break pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_EMPTY;
            owner_r  <= 1'b0;
            prio_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else if (hs0_s | hs1_s) begin
            result_r <= bus.alu_out;
            owner_r  <= hs1_s;
            state_r  <= ST_FULL;
`ifdef ALU_ARB_RR_EN
            // The port that was not served wins the next tie.
            prio_r   <= hs0_s;
`else
            prio_r   <= 1'b0;
`endif
        end else if (drain_s) begin
            state_r  <= ST_EMPTY;
        end else begin
            state_r  <= state_r;
        end
    end

    assign bus.rsp0_valid = (state_r == ST_FULL) & ~owner_r;
    assign bus.rsp1_valid = (state_r == ST_FULL) &  owner_r;
    assign bus.rsp_out    = result_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter. A behavioural ALU (op 000 = add, other ops =
// subtract) closes the loop on alu_out. Inputs change on the falling edge;
// combinational outputs are checked 1 ns later, registered outputs 1 ns after
// the rising edge. Expected values are hand-computed constants.
module tb_alu_arbiter;
    localparam int WIDTH    = 32;
    localparam int OP_WIDTH = 3;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    alu_arbiter_if #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    assign bus.alu_out = (bus.alu_op_code == 3'b000) ? (bus.alu_in_a + bus.alu_in_b)
                                                     : (bus.alu_in_a - bus.alu_in_b);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want summary before 100000 ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid   = v;
        bus.req0_in_a    = a;
        bus.req0_in_b    = b;
        bus.req0_op_code = 3'b000;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid   = v;
        bus.req1_in_a    = a;
        bus.req1_in_b    = b;
        bus.req1_op_code = 3'b000;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic exp_g1;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        drive0(1'b1, 32'd5, 32'd6);
        drive1(1'b0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset: a valid request must not be granted, everything reads zero.
        repeat (3) step();
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_alu_in_a",   bus.alu_in_a, 32'd0);
        chk("rst_alu_op",     {29'd0, bus.alu_op_code}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst_rsp_out",    bus.rsp_out, 32'd0);

        @(negedge clock);
        drive0(1'b0, 32'd0, 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_alu_op",     {29'd0, bus.alu_op_code}, 32'd0);
        chk("idle_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("idle_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);

        // Single op 1+1 on port 0 with immediate drain.
        @(negedge clock);
        drive0(1'b1, 32'd1, 32'd1);
        bus.rsp0_ready = 1'b1;
        #1;
        chk("single_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        chk("single_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        chk("single_alu_in_b",   bus.alu_in_b, 32'd1);
        step();
        chk("single_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("single_rsp_out",    bus.rsp_out, 32'd2);
        @(negedge clock);
        drive0(1'b0, 32'd0, 32'd0);
        step();
        chk("single_drained", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("single_hold_out", bus.rsp_out, 32'd2);

        // Tie: port 0 = 1+1, port 1 = 5+3, both responses always ready.
        // Round-robin: the last handshake was port 0, so port 1 wins first.
        @(negedge clock);
        bus.rsp1_ready = 1'b1;
        drive0(1'b1, 32'd1, 32'd1);
        drive1(1'b1, 32'd5, 32'd3);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_g1 = (i % 2 == 0);
`else
            exp_g1 = 1'b0;
`endif
            #1;
            chk("tie_req0_ready", {31'd0, bus.req0_ready}, {31'd0, ~exp_g1});
            chk("tie_req1_ready", {31'd0, bus.req1_ready}, {31'd0, exp_g1});
            step();
            chk("tie_rsp_out",    bus.rsp_out, exp_g1 ? 32'd8 : 32'd2);
            chk("tie_rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, exp_g1});
            @(negedge clock);
        end
        drive0(1'b0, 32'd0, 32'd0);
        drive1(1'b0, 32'd0, 32'd0);
        step();
        chk("tie_drained", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);

        // Backpressure: port 1 computes 7+0 and is not consumed for 4 cycles.
        @(negedge clock);
        bus.rsp1_ready = 1'b0;
        drive1(1'b1, 32'd7, 32'd0);
        #1;
        chk("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        @(negedge clock);
        drive1(1'b0, 32'd0, 32'd0);
        drive0(1'b1, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_req0_ready",  {31'd0, bus.req0_ready}, 32'd0);
            chk("bp_alu_in_a",    bus.alu_in_a, 32'd1);
            step();
            chk("bp_rsp1_valid",  {31'd0, bus.rsp1_valid}, 32'd1);
            chk("bp_rsp_out",     bus.rsp_out, 32'd7);
            @(negedge clock);
        end
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        step();
        chk("bp_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("bp_rsp1_valid_low", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("bp_new_out",    bus.rsp_out, 32'd2);
        @(negedge clock);
        drive0(1'b0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b1;
        step();
        chk("bp_drained", {31'd0, bus.rsp0_valid}, 32'd0);

        // Reset while a port 0 result (3+4) is pending.
        @(negedge clock);
        bus.rsp0_ready = 1'b0;
        drive0(1'b1, 32'd3, 32'd4);
        step();
        chk("mid_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("mid_rsp_out",    bus.rsp_out, 32'd7);
        @(negedge clock);
        drive0(1'b0, 32'd0, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_async_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("mid_async_out",   bus.rsp_out, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        repeat (2) begin
            step();
            chk("mid_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
